cnn_weight_loader: RTL and testbench

CNN_WEIGHT_LOADER -- requirements
Module: cnn_weight_loader

---
 rtl/cnn_weight_loader_if.sv | 43 ++++
 rtl/cnn_weight_loader.sv | 189 ++++++++++++++++++
 tb/tb_cnn_weight_loader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cnn_weight_loader_if.sv
`default_nettype none
// cnn_weight_loader_if: byte-stream input and memory write-port bundle of the CNN weight loader.
// Revision 1.0
interface cnn_weight_loader_if #(
   parameter int NUM_FEATURES = 3,
   parameter int KERNEL_SIZE  = 4,
   parameter int DATA_WIDTH   = 8,
   parameter int FC_ROW       = 16
);
   logic                                                 load_start;
   logic signed [DATA_WIDTH-1:0]                         in_data;
   logic                                                 in_valid;
   logic                                                 in_ready;
   logic [KERNEL_SIZE*KERNEL_SIZE-1:0][DATA_WIDTH-1:0]   feature_weights_output;
   logic [1:0]                                           feature_writeAddr;
   logic                                                 feature_WrEn;
   logic [NUM_FEATURES:0][DATA_WIDTH-1:0]                bias_weights_output;
   logic                                                 bias_WrEn;
   logic [FC_ROW-1:0][DATA_WIDTH-1:0]                    fullyconnected_weights_output;
   logic [4:0]                                           fullyconnected_writeAddr;
   logic                                                 fullyconnected_WrEn;
   logic                                                 convolution_enable;
   logic                                                 busy;
   logic                                                 done;
   logic                                                 load_error;

   modport slave (
      input  load_start, in_data, in_valid,
      output in_ready, feature_weights_output, feature_writeAddr, feature_WrEn,
             bias_weights_output, bias_WrEn, fullyconnected_weights_output,
             fullyconnected_writeAddr, fullyconnected_WrEn, convolution_enable,
             busy, done, load_error
   );

   modport master (
      output load_start, in_data, in_valid,
      input  in_ready, feature_weights_output, feature_writeAddr, feature_WrEn,
             bias_weights_output, bias_WrEn, fullyconnected_weights_output,
             fullyconnected_writeAddr, fullyconnected_WrEn, convolution_enable,
             busy, done, load_error
   );
endinterface
`default_nettype wire

// File: rtl/cnn_weight_loader.sv
`default_nettype none
// cnn_weight_loader: streams kernel, bias and fully-connected weight bytes into write buffers and
// pulses the memory write enables; optional trailing checksum byte under LOADER_CHECKSUM_EN. Revision 1.0
module cnn_weight_loader #(
   parameter int NUM_FEATURES     = 3,
   parameter int KERNEL_SIZE      = 4,
   parameter int FLATTENED_LENGTH = 432,
   parameter int DATA_WIDTH       = 8,
   parameter int FC_ROW           = 16
) (
   input  wire logic         clk,
   input  wire logic         rst_loader,
   cnn_weight_loader_if.slave bus
);
   localparam int KK      = KERNEL_SIZE * KERNEL_SIZE;
   localparam int NB      = NUM_FEATURES + 1;
   localparam int FC_ROWS = FLATTENED_LENGTH / FC_ROW;
   localparam int MAXN    = (KK > FC_ROW) ? ((KK > NB) ? KK : NB) : ((FC_ROW > NB) ? FC_ROW : NB);
   localparam int CNT_W   = $clog2(MAXN + 1);

   typedef enum logic [3:0] {
      IDLE, FEAT_COLLECT, FEAT_WRITE, BIAS_COLLECT, BIAS_WRITE,
      FC_COLLECT, FC_WRITE, CHECK, START, DONE
   } state_t;

   state_t                            state_q, state_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic                              wr_q, wr_d;
   logic [1:0]                        feat_addr_q, feat_addr_d;
   logic [4:0]                        fc_addr_q, fc_addr_d;
   logic [KK-1:0][DATA_WIDTH-1:0]     feat_q, feat_d;
   logic [NB-1:0][DATA_WIDTH-1:0]     bias_q, bias_d;
   logic [FC_ROW-1:0][DATA_WIDTH-1:0] fc_q, fc_d;
   logic                              w_in_ready;

`ifdef LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] sum_q;
   logic                  err_q;
`endif

   always_ff @(posedge clk) begin
      if (rst_loader) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         feat_addr_q <= '0;
         fc_addr_q   <= '0;
         feat_q      <= '0;
         bias_q      <= '0;
         fc_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         feat_addr_q <= feat_addr_d;
         fc_addr_q   <= fc_addr_d;
         feat_q      <= feat_d;
         bias_q      <= bias_d;
         fc_q        <= fc_d;
      end
   end

   always_comb begin
      w_in_ready = (state_q == FEAT_COLLECT) || (state_q == BIAS_COLLECT) || (state_q == FC_COLLECT);
`ifdef LOADER_CHECKSUM_EN
      if (state_q == CHECK) w_in_ready = 1'b1;
`endif
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      feat_addr_d = feat_addr_q;
      fc_addr_d   = fc_addr_q;
      feat_d      = feat_q;
      bias_d      = bias_q;
      fc_d        = fc_q;
      case (state_q)
         IDLE: begin
            if (bus.load_start) begin
               state_d     = FEAT_COLLECT;
               cnt_d       = '0;
               wr_d        = 1'b0;
               feat_addr_d = '0;
               fc_addr_d   = '0;
            end
         end
         FEAT_COLLECT: begin
            if (bus.in_valid) begin
               for (int i = 0; i < KK; i++)
                  if (cnt_q == CNT_W'(i)) feat_d[i] = bus.in_data;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(KK - 1)) begin
                  cnt_d   = '0;
                  state_d = FEAT_WRITE;
               end
            end
         end
         // wr_q marks the second of the two write cycles
         FEAT_WRITE: begin
            wr_d = ~wr_q;
            if (wr_q) begin
               feat_addr_d = feat_addr_q + 2'd1;
               state_d     = (feat_addr_q == 2'(NUM_FEATURES - 1)) ? BIAS_COLLECT : FEAT_COLLECT;
            end
         end
         BIAS_COLLECT: begin
            if (bus.in_valid) begin
               for (int i = 0; i < NB; i++)
                  if (cnt_q == CNT_W'(i)) bias_d[i] = bus.in_data;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(NB - 1)) begin
                  cnt_d   = '0;
                  state_d = BIAS_WRITE;
               end
            end
         end
         BIAS_WRITE: begin
            wr_d = ~wr_q;
            if (wr_q) begin
               fc_addr_d = '0;
               state_d   = FC_COLLECT;
            end
         end
         FC_COLLECT: begin
            if (bus.in_valid) begin
               for (int i = 0; i < FC_ROW; i++)
                  if (cnt_q == CNT_W'(i)) fc_d[i] = bus.in_data;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(FC_ROW - 1)) begin
                  cnt_d   = '0;
                  state_d = FC_WRITE;
               end
            end
         end
         FC_WRITE: begin
            wr_d = ~wr_q;
            if (wr_q) begin
               fc_addr_d = fc_addr_q + 5'd1;
               state_d   = (fc_addr_q == 5'(FC_ROWS - 1)) ? CHECK : FC_COLLECT;
            end
         end
         CHECK: begin
`ifdef LOADER_CHECKSUM_EN
            if (bus.in_valid) state_d = (bus.in_data == sum_q) ? START : DONE;
`else
            state_d = START;
`endif
         end
         START:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

`ifdef LOADER_CHECKSUM_EN
   // Running sum covers every weight byte; the byte taken in CHECK is only compared
   always_ff @(posedge clk) begin
      if (rst_loader) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else if (state_q == IDLE && bus.load_start) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else if (bus.in_valid && w_in_ready) begin
         if (state_q != CHECK) sum_q <= sum_q + bus.in_data;
         else if (bus.in_data != sum_q) err_q <= 1'b1;
      end
   end
   assign bus.load_error = err_q;
`else
   assign bus.load_error = 1'b0;
`endif

   assign bus.in_ready                      = w_in_ready;
   assign bus.feature_weights_output        = feat_q;
   assign bus.feature_writeAddr             = feat_addr_q;
   assign bus.feature_WrEn                  = (state_q != FEAT_WRITE);
   assign bus.bias_weights_output           = bias_q;
   assign bus.bias_WrEn                     = (state_q != BIAS_WRITE);
   assign bus.fullyconnected_weights_output = fc_q;
   assign bus.fullyconnected_writeAddr      = fc_addr_q;
   assign bus.fullyconnected_WrEn           = (state_q != FC_WRITE);
   assign bus.convolution_enable            = (state_q != START);
   assign bus.busy                          = (state_q != IDLE);
   assign bus.done                          = (state_q == DONE);
endmodule
`default_nettype wire

// File: tb/tb_cnn_weight_loader.sv
`default_nettype none
// tb_cnn_weight_loader: randomized byte streams against a queue-based model of the expected memory writes.
// Revision 1.0
module tb_cnn_weight_loader;
   localparam int NF = 3, KS = 4, FL = 432, DW = 8, FCR = 16;
   localparam int NBYTES = KS*KS*NF + (NF+1) + FL;

   typedef struct {
      int           kind;
      int           addr;
      logic [127:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0, bad = 0;
   int   edges = 0;
   int   n_wr = 0, n_conv = 0, n_done = 0;
   int   conv_edge = 0, done_edge = 0, last_fc = -1, ls_edges = 0;
   wr_t  sbq[$];

   cnn_weight_loader_if #(.NUM_FEATURES(NF), .KERNEL_SIZE(KS), .DATA_WIDTH(DW), .FC_ROW(FCR)) bus ();

   cnn_weight_loader #(
      .NUM_FEATURES(NF), .KERNEL_SIZE(KS), .FLATTENED_LENGTH(FL), .DATA_WIDTH(DW), .FC_ROW(FCR)
   ) dut (
      .clk(clk),
      .rst_loader(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edges <= edges + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: pops the expected write on the first low cycle of every write pulse
   logic [2:0]   prev_low = 3'b000;
   int           len = 0, hold_a = 0;
   logic [127:0] hold_d = '0;
   always @(negedge clk) begin
      logic [2:0]   low;
      logic [127:0] d;
      int           a, k;
      wr_t          e;
      low = ~{bus.fullyconnected_WrEn, bus.bias_WrEn, bus.feature_WrEn};
      d = '0;
      if (low[0]) begin
         k = 0; a = int'(bus.feature_writeAddr); d = bus.feature_weights_output;
      end else if (low[1]) begin
         k = 1; a = 0; d[(NF+1)*DW-1:0] = bus.bias_weights_output;
      end else begin
         k = 2; a = int'(bus.fullyconnected_writeAddr); d = bus.fullyconnected_weights_output;
      end
      if (!rst && low != 3'b000) begin
         if (prev_low == 3'b000) begin
            n_wr++;
            if (sbq.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_write actual=kind%0d addr%0d required=none", k, a);
            end else begin
               e = sbq.pop_front();
               chk("wr_kind", 128'(k), 128'(e.kind));
               chk("wr_addr", 128'(a), 128'(e.addr));
               chk("wr_data", d, e.data);
            end
            if (k == 2) last_fc = a;
            hold_d = d; hold_a = a; len = 1;
         end else begin
            len++;
            chk("wr_data_stable", d, hold_d);
            chk("wr_addr_stable", 128'(a), 128'(hold_a));
         end
      end else if (!rst && prev_low != 3'b000) begin
         chk("wr_len", 128'(len), 128'd2);
      end
      prev_low = rst ? 3'b000 : low;
      if (!rst && !bus.convolution_enable) begin n_conv++; conv_edge = edges; end
      if (!rst && bus.done) begin n_done++; done_edge = edges; end
   end

   // ck: 0 no checksum byte, 1 correct checksum byte, 2 wrong checksum byte
   task automatic run_load(input int gap_pct, input int abort_at, input int ck);
      logic [7:0] b[NBYTES];
      logic [7:0] sum;
      wr_t        e;
      int         idx, nb, guard;
      bit         acc;
      sum = 8'd0;
      for (int i = 0; i < NBYTES; i++) b[i] = 8'($urandom);
      b[0] = 8'(-53); b[1] = 8'(43); b[15] = 8'(26);
      for (int i = 0; i < NBYTES; i++) sum = sum + b[i];
      for (int f = 0; f < NF; f++) begin
         e.kind = 0; e.addr = f; e.data = '0;
         for (int i = 0; i < KS*KS; i++) e.data[i*8 +: 8] = b[f*KS*KS + i];
         sbq.push_back(e);
      end
      e.kind = 1; e.addr = 0; e.data = '0;
      for (int i = 0; i <= NF; i++) e.data[i*8 +: 8] = b[NF*KS*KS + i];
      sbq.push_back(e);
      for (int r = 0; r < FL/FCR; r++) begin
         e.kind = 2; e.addr = r; e.data = '0;
         for (int i = 0; i < FCR; i++) e.data[i*8 +: 8] = b[NF*KS*KS + NF + 1 + r*FCR + i];
         sbq.push_back(e);
      end
      n_wr = 0; n_conv = 0; n_done = 0; last_fc = -1;
      nb = NBYTES + ((ck != 0) ? 1 : 0);
      @(negedge clk);
      bus.load_start = 1'b1; bus.in_valid = 1'b0; ls_edges = edges;
      @(negedge clk);
      bus.load_start = 1'b0;
      idx = 0; guard = 0;
      while (idx < nb) begin
         if (abort_at > 0 && idx == abort_at) begin
            rst = 1'b1; bus.in_valid = 1'b0; sbq.delete();
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         bus.in_valid   = ($urandom_range(99) >= gap_pct);
         bus.in_data    = (idx < NBYTES) ? b[idx] : ((ck == 1) ? sum : sum + 8'd1);
         bus.load_start = (gap_pct > 0) && ($urandom_range(19) == 0);
         acc = bus.in_valid && bus.in_ready;
         @(negedge clk);
         if (acc) idx++;
         guard++;
         if (guard > 20000) begin
            total++; bad++;
            $display("FAIL stream_timeout actual=%0d required=%0d", idx, nb);
            break;
         end
      end
      bus.in_valid = 1'b0; bus.load_start = 1'b0;
      for (int t = 0; t < 100 && n_done == 0; t++) @(negedge clk);
      @(negedge clk);
      chk("done_pulses", 128'(n_done), 128'd1);
      chk("write_pulses", 128'(n_wr), 128'd31);
      chk("last_fc_addr", 128'(last_fc), 128'd26);
      chk("sb_empty", 128'(sbq.size()), 128'd0);
      chk("busy_after", 128'(bus.busy), 128'd0);
      chk("load_error", 128'(bus.load_error), 128'(ck == 2));
      if (ck == 2) chk("conv_pulses", 128'(n_conv), 128'd0);
      else begin
         chk("conv_pulses", 128'(n_conv), 128'd1);
         chk("done_after_conv", 128'(done_edge), 128'(conv_edge + 1));
      end
      if (gap_pct == 0 && ck == 0) chk("conv_cycle", 128'(conv_edge - ls_edges + 1), 128'd549);
   endtask

   initial begin
      bus.load_start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_feature_WrEn", 128'(bus.feature_WrEn), 128'd1);
      chk("rst_bias_WrEn", 128'(bus.bias_WrEn), 128'd1);
      chk("rst_fc_WrEn", 128'(bus.fullyconnected_WrEn), 128'd1);
      chk("rst_conv_en", 128'(bus.convolution_enable), 128'd1);
      chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
      chk("rst_busy", 128'(bus.busy), 128'd0);
      chk("rst_done", 128'(bus.done), 128'd0);
      chk("rst_load_error", 128'(bus.load_error), 128'd0);

`ifdef LOADER_CHECKSUM_EN
      run_load(0, 0, 2);
      run_load(25, 0, 1);
      run_load(0, 0, 1);
`else
      run_load(0, 0, 0);
      run_load(30, 0, 0);
      run_load(60, 0, 0);
`endif
      // Abort during the third fully-connected row
      run_load(0, KS*KS*NF + NF + 1 + 2*FCR + 7, 0);
      repeat (40) @(negedge clk);
      chk("abort_writes", 128'(n_wr), 128'd6);
      chk("abort_busy", 128'(bus.busy), 128'd0);
      chk("abort_conv", 128'(n_conv), 128'd0);
      chk("abort_done", 128'(n_done), 128'd0);
`ifdef LOADER_CHECKSUM_EN
      run_load(10, 0, 1);
`else
      run_load(10, 0, 0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
